// File: rtl/alu_exec_stage.sv
// Execute stage: 4-op ALU with {Z,N,V} status register and a 2-entry result
// queue toward writeback, valid/ready on both sides.
module alu_exec_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic [1:0]       aluop,
  input  logic             loadc,
  input  logic             loads,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c_out,
  output logic [2:0]       status
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] FULL   = 2'(DEPTH);

  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic signed [WIDTH-1:0] result_p0;
  logic [2:0]              flags_p0;
  logic                    vld_p0;
  logic                    push_p0;
  logic                    pop;

  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [2:0]       status_q;
  logic [WIDTH-1:0] mem [DEPTH];

  function automatic logic signed [WIDTH-1:0] alu_result(
    input logic [1:0]              op,
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      default: return ~b;
    endcase
  endfunction

  // Overflow only exists for the arithmetic ops; logic ops always clear V.
  function automatic logic [2:0] alu_flags(
    input logic [1:0]              op,
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input logic signed [WIDTH-1:0] r
  );
    logic v;
    v = 1'b0;
    case (op)
      OP_ADD:  v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      OP_SUB:  v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      default: v = 1'b0;
    endcase
    return {r == '0, r[WIDTH-1], v};
  endfunction

  // Stage p0: combinational ALU and handshake decode
  assign a_p0      = ain;
  assign b_p0      = bin;
  assign result_p0 = alu_result(aluop, a_p0, b_p0);
  assign flags_p0  = alu_flags(aluop, a_p0, b_p0, result_p0);

  assign in_ready  = (count != FULL);
  assign out_valid = (count != 2'd0);
  assign vld_p0    = in_valid & in_ready;
  assign push_p0   = vld_p0 & loadc;
  assign pop       = out_valid & out_ready;

  // Queue control and architectural status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      status_q <= 3'b000;
    end else begin
      if (push_p0) wr_ptr <= ~wr_ptr;
      if (pop)     rd_ptr <= ~rd_ptr;
      case ({push_p0, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (vld_p0 && loads) status_q <= flags_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_p0) mem[wr_ptr] <= result_p0;
  end

  // Empty queue forces zero so stale or never-written entries stay invisible.
  assign c_out  = out_valid ? mem[rd_ptr] : '0;
  assign status = status_q;

endmodule
